avg_accumulator: RTL and testbench
==================================

# avg_accumulator

Waveform-averaging accumulation engine for the ADC averager. It consumes the power-of-two record count N produced by the log2 decoding stage and the ADC sample stream. On each trigger it sums one record of samples, point by point, into an internal accumulator memory, for N records in total. When done it exposes the sums through a registered read port, so software can divide by shifting right by log2N.

## Interface
Parameters:
- DATA_W, 14, width of the signed ADC sample
- ACC_W, 32, width of each accumulator word; sums wrap modulo 2^ACC_W
- ADDR_W, 10, log2 of the memory depth; maximum record length is 2^ADDR_W samples

Ports:
- clk  in  1  system clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE
- naverages  in  32  N, the number of records to average; latched on start; 0 is treated as 1
- nsamples  in  ADDR_W  record length minus 1; latched on start
- trig  in  1  record trigger, level-sampled, honoured only in ARM
- s_tdata  in  DATA_W  signed ADC sample
- s_tvalid  in  1  s_tdata is valid this cycle; there is no backpressure and every valid sample in ACQ is consumed
- busy  out  1  high in ARM and ACQ, and while pipeline writes drain
- done  out  1  high in DONE until the next start or rst
- rec_count  out  32  number of completed records in the current run
- rd_addr  in  ADDR_W  readout address
- rd_data  out  ACC_W  accumulator word at rd_addr, registered with 1-cycle latency

## Operation
- FSM states: IDLE, ARM, ACQ, DONE.
- IDLE or DONE → ARM on start:
  - latch naverages and nsamples;
  - clear rec_count and the sample index;
  - drop done.
- ARM → ACQ on the first cycle with trig=1. Only samples that arrive in later cycles belong to the record.
- In ACQ, each cycle with s_tvalid=1 processes one sample at index i, starting from 0:
  - sign-extend the sample to ACC_W;
  - if rec_count=0, write it to mem[i] (this replaces the old contents, so no clear pass is needed);
  - otherwise, write mem[i] + sample to mem[i].
- The sample with i = nsamples ends the record:
  - rec_count increments;
  - i resets to 0;
  - the FSM goes to DONE if the new rec_count equals the latched N (or 1 when N was 0), and to ARM otherwise.
- Cycles with s_tvalid=0 in ACQ change nothing.
- trig is ignored outside ARM.
- start is ignored in ARM and ACQ.
- The accumulation pipeline is read-modify-write in two stages:
  - stage 1 presents address i to the memory;
  - stage 2 adds the sample and writes.
  - Consecutive samples always have distinct addresses, and the ARM cycle separates the last address of one record from address 0 of the next, so no forwarding is required.
- Arithmetic is two's complement modulo 2^ACC_W. Results are exact whenever DATA_W + log2N ≤ ACC_W (for example log2N ≤ 18 at the defaults). No saturation is applied.
- The read port is always active. Reads while busy return partial sums. Memory addresses above nsamples keep stale data.
- rst in any state, including mid-record:
  - state goes to IDLE;
  - busy=0, done=0, rec_count=0, rd_data=0;
  - memory contents are untouched, and the next run overwrites them on record 0.

## Timing
- Reset values: busy=0, done=0, rec_count=0, rd_data=0, state IDLE.
- start seen at cycle t → state ARM and busy=1 at t+1.
- trig seen in ARM at cycle t → state ACQ at t+1; the first eligible sample is at t+1.
- A sample accepted at cycle t is written to memory at the end of cycle t+1.
- The final sample of the final record, accepted at cycle t, gives:
  - rec_count = N at t+1;
  - busy=0 and done=1 at t+2, when the last write is visible;
  - a read issued at t+2 returns the final sum at t+3.
- rd_addr presented at cycle t → rd_data valid at t+1.
- A record of L = nsamples+1 samples with continuous s_tvalid occupies exactly L ACQ cycles, plus at least 1 ARM cycle between records.

## Test plan
- **Constant input.** N=4, nsamples=7, s_tdata=+100 continuous, trig pulsed 4 times → done; mem[0..7]=400; rec_count=4; done exactly 2 cycles after the last sample.
- **Ramp with negative values.** N=2, nsamples=3; record 0 is −5,−1,0,7 and record 1 is 5,−3,−8,1 → mem = 0, −4, −8, 8 as 32-bit two's complement (mem[2] = 0xFFFFFFF8).
- **Gapped valid and ignored triggers.** s_tvalid toggling 1,0,1,0 and trig held high during ACQ → sums identical to the continuous case; extra triggers do not start new records; rec_count increments once per record.
- **Overwrite on record 0.** Run N=2 with sample 50, then a second run with N=1 and sample 3 and no reset → mem=3, not 103.
- **Reset mid-record.** rst asserted in ACQ after 3 of 8 samples → next cycle busy=0, done=0, rec_count=0, state IDLE; a fresh run then gives correct sums.
- **Edge cases.**
  - naverages=0 → behaves as N=1.
  - nsamples=0 → one-sample records, with mem[0] equal to the sum of N trigger-aligned samples.
  - Full wrap at ACC_W=16 with sample 0x1FFF and N=16 → mem = 0xFFF0.

Source files
------------

// File: rtl/avg_accumulator_if.sv
// Control, sample-stream and readout signals of the ADC averaging engine.
// The testbench or host drives the master side; the accumulator is the slave.
interface avg_accumulator_if #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic [31:0]       naverages;
    logic [ADDR_W-1:0] nsamples;
    logic              trig;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              busy;
    logic              done;
    logic [31:0]       rec_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [ACC_W-1:0]  rd_data;

    modport master (
        output start, naverages, nsamples, trig, s_tdata, s_tvalid, rd_addr,
        input  busy, done, rec_count, rd_data
    );

    modport slave (
        input  start, naverages, nsamples, trig, s_tdata, s_tvalid, rd_addr,
        output busy, done, rec_count, rd_data
    );
endinterface

// File: rtl/avg_accumulator.sv
// Point-by-point accumulation of N triggered ADC records into an internal memory,
// with a two-stage read-modify-write pipeline and a registered readout port.
module avg_accumulator #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 10
) (
    input logic             clk,
    input logic             rst,
    avg_accumulator_if.slave bus
);
    localparam int unsigned ExtW = ACC_W - DATA_W;

    typedef enum logic [1:0] {StIdle, StArm, StAcq, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       navg_q, navg_d;
    logic [ADDR_W-1:0] nsamp_q, nsamp_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       rec_q, rec_d;

    logic              accept;
    logic [ACC_W-1:0]  sample_ext;

    logic              wr_en_q;
    logic              wr_first_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ACC_W-1:0]  wr_sample_q;
    logic [ACC_W-1:0]  rd_old_q;
    logic [ACC_W-1:0]  rd_data_q;

    logic [ACC_W-1:0]  mem [2**ADDR_W];

    assign accept     = (state_q == StAcq) && bus.s_tvalid;
    assign sample_ext = {{ExtW{bus.s_tdata[DATA_W-1]}}, bus.s_tdata};

    always_comb begin
        state_d = state_q;
        navg_d  = navg_q;
        nsamp_d = nsamp_q;
        idx_d   = idx_q;
        rec_d   = rec_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StArm;
                    navg_d  = (bus.naverages == 32'd0) ? 32'd1 : bus.naverages;
                    nsamp_d = bus.nsamples;
                    idx_d   = '0;
                    rec_d   = '0;
                end
            end
            StArm: begin
                if (bus.trig) state_d = StAcq;
            end
            StAcq: begin
                if (bus.s_tvalid) begin
                    if (idx_q == nsamp_q) begin
                        idx_d   = '0;
                        rec_d   = rec_q + 32'd1;
                        state_d = (rec_q + 32'd1 == navg_q) ? StDone : StArm;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            navg_q    <= 32'd1;
            nsamp_q   <= '0;
            idx_q     <= '0;
            rec_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            navg_q    <= navg_d;
            nsamp_q   <= nsamp_d;
            idx_q     <= idx_d;
            rec_q     <= rec_d;
            wr_en_q   <= accept;
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    // Stage 1 latches the old word; stage 2 writes. Record 0 replaces stale contents.
    always_ff @(posedge clk) begin
        wr_first_q  <= (rec_q == 32'd0);
        wr_addr_q   <= idx_q;
        wr_sample_q <= sample_ext;
        rd_old_q    <= mem[idx_q];
        if (wr_en_q) begin
            mem[wr_addr_q] <= wr_first_q ? wr_sample_q : rd_old_q + wr_sample_q;
        end
    end

    // done waits for the final write so a read issued then sees the complete sum.
    assign bus.busy      = (state_q == StArm) || (state_q == StAcq) || wr_en_q;
    assign bus.done      = (state_q == StDone) && !wr_en_q;
    assign bus.rec_count = rec_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_avg_accumulator.sv
// Bench for avg_accumulator: a cycle-level reference model checked every cycle,
// plus directed runs with literal expected sums.
module tb_avg_accumulator;
    logic clk;
    logic rst;

    avg_accumulator_if #(.DATA_W(14), .ACC_W(32), .ADDR_W(10)) bus ();
    avg_accumulator_if #(.DATA_W(14), .ACC_W(16), .ADDR_W(10)) bus16 ();

    avg_accumulator #(.DATA_W(14), .ACC_W(32), .ADDR_W(10)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    avg_accumulator #(.DATA_W(14), .ACC_W(16), .ADDR_W(10)) dut16 (
        .clk(clk),
        .rst(rst),
        .bus(bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer bookkeeping of the run rules.
    int          m_mode = 0;  // 0 idle, 1 arm, 2 acq, 3 done
    int          m_idx, m_cnt, m_navg, m_len;
    bit          m_pend = 0;
    int          m_pend_addr;
    logic [31:0] m_mem [0:1023];
    bit          m_known [0:1023];
    bit          model_on = 0;
    bit          chk_en = 1;
    bit          exp_busy, exp_done, exp_rd_ok;
    logic [31:0] exp_rec, exp_rd, v;

    always @(posedge clk) begin
        if (rst) begin
            model_on  = 1;
            if (m_pend) m_known[m_pend_addr] = 0;
            m_mode    = 0;
            m_cnt     = 0;
            m_pend    = 0;
            exp_rd    = 0;
            exp_rd_ok = 1;
        end else if (model_on) begin
            exp_rd_ok = !m_pend && m_known[bus.rd_addr];
            exp_rd    = m_mem[bus.rd_addr];
            m_pend    = 0;
            if ((m_mode == 0 || m_mode == 3) && bus.start) begin
                m_mode = 1;
                m_navg = (bus.naverages == 0) ? 1 : int'(bus.naverages);
                m_len  = int'(bus.nsamples) + 1;
                m_cnt  = 0;
                m_idx  = 0;
            end else if (m_mode == 1 && bus.trig) begin
                m_mode = 2;
            end else if (m_mode == 2 && bus.s_tvalid) begin
                v = {{18{bus.s_tdata[13]}}, bus.s_tdata};
                m_mem[m_idx]   = (m_cnt == 0) ? v : m_mem[m_idx] + v;
                m_known[m_idx] = (m_cnt == 0) || m_known[m_idx];
                m_pend         = 1;
                m_pend_addr    = m_idx;
                m_idx++;
                if (m_idx == m_len) begin
                    m_idx = 0;
                    m_cnt++;
                    m_mode = (m_cnt == m_navg) ? 3 : 1;
                end
            end
        end
        exp_busy = (m_mode == 1 || m_mode == 2) || m_pend;
        exp_done = (m_mode == 3) && !m_pend;
        exp_rec  = m_cnt;
    end

    always @(negedge clk) begin
        if (model_on && chk_en) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
            chk("done", {31'd0, bus.done}, {31'd0, exp_done});
            chk("rec_count", bus.rec_count, exp_rec);
            if (exp_rd_ok) chk("rd_data", bus.rd_data, exp_rd);
        end
    end

    logic [13:0] rec_data [0:15];

    task automatic fill(input int val);
        for (int i = 0; i < 16; i++) rec_data[i] = 14'(val);
    endtask

    task automatic start_run(input int n, input int ns);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.naverages = n;
        bus.nsamples  = 10'(ns);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic record(input int len, input bit gap, input bit hold);
        @(negedge clk);
        bus.trig     = 1'b1;
        bus.s_tvalid = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            bus.trig     = hold;
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = rec_data[i];
            bus.rd_addr  = 10'(i);
            if (gap) begin
                @(negedge clk);
                bus.s_tvalid = 1'b0;
                if (i == len - 1) bus.trig = 1'b0;
            end
        end
        @(negedge clk);
        bus.trig     = 1'b0;
        bus.s_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20 && !bus.done; k++) @(negedge clk);
        chk("done_wait", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic read_check(input string name, input int addr, input logic [31:0] exp);
        @(negedge clk);
        bus.rd_addr = 10'(addr);
        @(negedge clk);
        chk(name, bus.rd_data, exp);
        chk({name, "_model"}, m_mem[addr], exp);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.naverages = 0; bus.nsamples = 0; bus.trig = 0;
        bus.s_tdata = 0; bus.s_tvalid = 0; bus.rd_addr = 0;
        bus16.start = 0; bus16.naverages = 0; bus16.nsamples = 0; bus16.trig = 0;
        bus16.s_tdata = 0; bus16.s_tvalid = 0; bus16.rd_addr = 0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_rd_data", bus.rd_data, 32'd0);
        rst = 1'b0;

        // Constant input, done exactly 2 cycles after the last sample
        start_run(4, 7);
        fill(100);
        repeat (4) record(8, 0, 0);
        chk("const_rec_count", bus.rec_count, 32'd4);
        chk("const_done_early", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        chk("const_done", {31'd0, bus.done}, 32'd1);
        read_check("const_mem0", 0, 32'd400);
        read_check("const_mem7", 7, 32'd400);

        // Ramp with negative values
        start_run(2, 3);
        rec_data[0] = 14'(-5); rec_data[1] = 14'(-1); rec_data[2] = 14'(0); rec_data[3] = 14'(7);
        record(4, 0, 0);
        rec_data[0] = 14'(5); rec_data[1] = 14'(-3); rec_data[2] = 14'(-8); rec_data[3] = 14'(1);
        record(4, 0, 0);
        wait_done();
        read_check("ramp_mem0", 0, 32'h0000_0000);
        read_check("ramp_mem1", 1, 32'hFFFF_FFFC);
        read_check("ramp_mem2", 2, 32'hFFFF_FFF8);
        read_check("ramp_mem3", 3, 32'h0000_0008);

        // Gapped valid with trig held through acquisition
        start_run(4, 7);
        fill(100);
        repeat (4) record(8, 1, 1);
        wait_done();
        chk("gap_rec_count", bus.rec_count, 32'd4);
        read_check("gap_mem3", 3, 32'd400);

        // Record 0 overwrites the previous run's sums
        start_run(2, 3);
        fill(50);
        repeat (2) record(4, 0, 0);
        wait_done();
        start_run(1, 3);
        fill(3);
        record(4, 0, 0);
        wait_done();
        read_check("ovw_mem0", 0, 32'd3);
        read_check("ovw_mem3", 3, 32'd3);

        // Reset after 3 of 8 samples
        start_run(4, 7);
        @(negedge clk);
        bus.trig = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.trig = 1'b0;
            bus.s_tvalid = 1'b1;
            bus.s_tdata = 14'(77);
        end
        @(negedge clk);
        bus.s_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_rec_count", bus.rec_count, 32'd0);
        start_run(1, 7);
        for (int i = 0; i < 8; i++) rec_data[i] = 14'(i * 3 - 10);
        record(8, 0, 0);
        wait_done();
        read_check("rst_mem0", 0, 32'hFFFF_FFF6);
        read_check("rst_mem7", 7, 32'd11);

        // naverages = 0 acts as one record
        start_run(0, 2);
        fill(7);
        record(3, 0, 0);
        wait_done();
        chk("n0_rec_count", bus.rec_count, 32'd1);
        read_check("n0_mem2", 2, 32'd7);

        // One-sample records
        start_run(3, 0);
        rec_data[0] = 14'(10); record(1, 0, 0);
        rec_data[0] = 14'(20); record(1, 0, 0);
        rec_data[0] = 14'(-5); record(1, 0, 0);
        wait_done();
        read_check("ns0_mem0", 0, 32'd25);

        // 16-bit accumulator wrap: 16 * 0x1FFF mod 2^16
        @(negedge clk);
        bus16.naverages = 16;
        bus16.nsamples  = 0;
        bus16.start     = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        repeat (16) begin
            @(negedge clk);
            bus16.trig = 1'b1;
            bus16.s_tvalid = 1'b0;
            @(negedge clk);
            bus16.trig = 1'b0;
            bus16.s_tvalid = 1'b1;
            bus16.s_tdata = 14'h1FFF;
        end
        @(negedge clk);
        bus16.s_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrap_done", {31'd0, bus16.done}, 32'd1);
        chk("wrap_rec_count", bus16.rec_count, 32'd16);
        chk("wrap_mem0", {16'd0, bus16.rd_data}, 32'h0000_FFF0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end
endmodule
